// File: rtl/nn_seq_pkg.sv
// Shared FSM state and mode encodings for the neuron operand sequencer.
package nn_seq_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  localparam logic MODE_SEQ    = 1'b0;
  localparam logic MODE_SINGLE = 1'b1;

endpackage

// File: rtl/nn_operand_select.sv
// Combinational lane picker: lane value, bias at index N_IN, zero plus error above it.
// Zero latency, no flow control.
module nn_operand_select
  import nn_seq_pkg::*;
#(
  parameter int WIDTH    = 7,
  parameter int N_IN     = 4,
  parameter int BIAS_VAL = 1,
  parameter int SELW     = $clog2(N_IN + 1)
) (
  input  logic [N_IN*WIDTH-1:0] hold_i,
  input  logic [SELW-1:0]       idx_i,
  output logic [WIDTH-1:0]      data_o,
  output logic                  err_o
);

  localparam logic [WIDTH-1:0] BIAS_W = WIDTH'(BIAS_VAL);

  always_comb begin
    data_o = '0;
    err_o  = 1'b0;
    if (idx_i == SELW'(N_IN)) begin
      data_o = BIAS_W;
    end else if (idx_i > SELW'(N_IN)) begin
      err_o = 1'b1;
    end
    for (int i = 0; i < N_IN; i++) begin
      if (idx_i == SELW'(i)) begin
        data_o = hold_i[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/nn_operand_sequencer.sv
// Streams captured operands (plus bias) one per beat to the neuron MAC, or one chosen operand.
// First beat 1 cycle after accepted start; beats hold while out_ready is low, start ignored while busy.
module nn_operand_sequencer
  import nn_seq_pkg::*;
#(
  parameter  int WIDTH    = 7,
  parameter  int N_IN     = 4,
  parameter  int BIAS_VAL = 1,
  localparam int SELW     = $clog2(N_IN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [SELW-1:0]       sel,
  input  logic [N_IN*WIDTH-1:0] din,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SELW-1:0]       out_idx,
  output logic                  out_last,
  output logic                  out_err,
  output logic                  busy
);

  state_e                  state_q;
  logic [N_IN*WIDTH-1:0]   hold_q;
  logic                    out_valid_q;
  logic [WIDTH-1:0]        out_data_q;
  logic [SELW-1:0]         out_idx_q;
  logic                    out_last_q;
  logic                    out_err_q;
  logic                    busy_q;

  logic [N_IN*WIDTH-1:0]   pick_src_d;
  logic [SELW-1:0]         pick_idx_d;
  logic                    pick_last_d;
  logic [WIDTH-1:0]        pick_data;
  logic                    pick_err;
  logic                    handshake;

  assign handshake = out_valid_q && out_ready;

  // The picker always computes the *next* beat: from din in IDLE so the first beat
  // lands one edge after start, from the holding register afterwards.
  always_comb begin
    pick_src_d  = hold_q;
    pick_idx_d  = out_idx_q + SELW'(1);
    pick_last_d = (pick_idx_d == SELW'(N_IN));
    if (state_q == ST_IDLE) begin
      pick_src_d  = din;
      pick_idx_d  = (mode == MODE_SINGLE) ? sel : '0;
      pick_last_d = (mode == MODE_SINGLE);
    end
  end

  nn_operand_select #(
    .WIDTH    (WIDTH),
    .N_IN     (N_IN),
    .BIAS_VAL (BIAS_VAL),
    .SELW     (SELW)
  ) u_select (
    .hold_i (pick_src_d),
    .idx_i  (pick_idx_d),
    .data_o (pick_data),
    .err_o  (pick_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      out_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_STREAM;
            hold_q      <= din;
            busy_q      <= 1'b1;
            out_valid_q <= 1'b1;
            out_data_q  <= pick_data;
            out_idx_q   <= pick_idx_d;
            out_last_q  <= pick_last_d;
            out_err_q   <= pick_err;
          end
        end
        ST_STREAM: begin
          if (handshake) begin
            if (out_last_q) begin
              state_q     <= ST_IDLE;
              busy_q      <= 1'b0;
              out_valid_q <= 1'b0;
              out_data_q  <= '0;
              out_idx_q   <= '0;
              out_last_q  <= 1'b0;
              out_err_q   <= 1'b0;
            end else begin
              out_data_q  <= pick_data;
              out_idx_q   <= pick_idx_d;
              out_last_q  <= pick_last_d;
              out_err_q   <= pick_err;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign out_err   = out_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_nn_operand_sequencer.sv
// Bench for nn_operand_sequencer: directed tables/sequences plus randomized traffic against a beat-queue model.
module tb_nn_operand_sequencer;
  import nn_seq_pkg::*;

  localparam int W   = 7;
  localparam int N   = 4;
  localparam int SW  = 3;
  localparam int W2  = 12;
  localparam int N2  = 6;
  localparam int SW2 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, start, mode, out_ready;
  logic [SW-1:0]     sel;
  logic [N*W-1:0]    din;
  logic              out_valid, out_last, out_err, busy;
  logic [W-1:0]      out_data;
  logic [SW-1:0]     out_idx;

  logic              start2, mode2, out_ready2;
  logic [SW2-1:0]    sel2;
  logic [N2*W2-1:0]  din2;
  logic              out_valid2, out_last2, out_err2, busy2;
  logic [W2-1:0]     out_data2;
  logic [SW2-1:0]    out_idx2;

  nn_operand_sequencer #(.WIDTH(W), .N_IN(N), .BIAS_VAL(1)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .sel(sel), .din(din),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .out_err(out_err), .busy(busy)
  );

  nn_operand_sequencer #(.WIDTH(W2), .N_IN(N2), .BIAS_VAL(5000)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .mode(mode2), .sel(sel2), .din(din2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .out_idx(out_idx2), .out_last(out_last2), .out_err(out_err2), .busy(busy2)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_beat(input string nm, input logic [W-1:0] d, input logic [SW-1:0] ix,
                            input logic l, input logic e);
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk({nm, "_busy"},  32'(busy),      32'd1);
    chk({nm, "_data"},  32'(out_data),  32'(d));
    chk({nm, "_idx"},   32'(out_idx),   32'(ix));
    chk({nm, "_last"},  32'(out_last),  32'(l));
    chk({nm, "_err"},   32'(out_err),   32'(e));
  endtask

  task automatic check_idle(input string nm);
    chk({nm, "_valid"}, 32'(out_valid), 32'd0);
    chk({nm, "_busy"},  32'(busy),      32'd0);
  endtask

  // Reference model: a request is the list of beats it must produce.
  typedef struct {
    logic [W-1:0]  data;
    logic [SW-1:0] idx;
    logic          last;
    logic          err;
  } beat_t;

  beat_t mq[$];

  task automatic push_req(input logic m, input logic [SW-1:0] s, input logic [N*W-1:0] d);
    beat_t b;
    int bias_exp;
    bias_exp = 1 % (1 << W);
    if (m == MODE_SEQ) begin
      for (int i = 0; i <= N; i++) begin
        b.data = (i < N) ? d[i*W +: W] : W'(bias_exp);
        b.idx  = SW'(i);
        b.last = (i == N);
        b.err  = 1'b0;
        mq.push_back(b);
      end
    end else begin
      b.idx  = s;
      b.last = 1'b1;
      b.err  = (int'(s) > N);
      if (int'(s) < N)       b.data = d[int'(s)*W +: W];
      else if (int'(s) == N) b.data = W'(bias_exp);
      else                   b.data = '0;
      mq.push_back(b);
    end
  endtask

  typedef struct {
    logic [SW-1:0] sel;
    logic [W-1:0]  exp_data;
    logic          exp_err;
  } svec_t;

  svec_t tbl[8];
  int    exp_seq[5];
  logic [N*W-1:0] din0;

  initial begin
    din0 = {7'd40, 7'd30, 7'd20, 7'd10};
    exp_seq = '{10, 20, 30, 40, 1};
    tbl[0] = '{3'd0, 7'd10, 1'b0};
    tbl[1] = '{3'd1, 7'd20, 1'b0};
    tbl[2] = '{3'd2, 7'd30, 1'b0};
    tbl[3] = '{3'd3, 7'd40, 1'b0};
    tbl[4] = '{3'd4, 7'd1,  1'b0};
    tbl[5] = '{3'd5, 7'd0,  1'b1};
    tbl[6] = '{3'd6, 7'd0,  1'b1};
    tbl[7] = '{3'd7, 7'd0,  1'b1};

    rst = 1'b1; start = 1'b1; mode = MODE_SEQ; sel = '0; din = din0; out_ready = 1'b1;
    start2 = 1'b0; mode2 = MODE_SEQ; sel2 = '0; din2 = '0; out_ready2 = 1'b1;

    // Reset, with start held high: reset must win.
    step();
    step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_idx",   32'(out_idx),   32'd0);
    chk("rst_last",  32'(out_last),  32'd0);
    chk("rst_err",   32'(out_err),   32'd0);
    rst = 1'b0; start = 1'b0;
    step();
    check_idle("idle0");

    // Default SEQ stream; start on the final-handshake cycle is ignored.
    start = 1'b1; mode = MODE_SEQ; din = din0;
    step();
    start = 1'b0;
    for (int i = 0; i <= N; i++) begin
      check_beat("seq", W'(exp_seq[i]), SW'(i), i == N, 1'b0);
      if (i == N) start = 1'b1;
      step();
    end
    check_idle("seq_after");
    step();
    start = 1'b0;
    check_beat("restart0", 7'd10, 3'd0, 1'b0, 1'b0);
    for (int i = 1; i <= N; i++) begin
      step();
      check_beat("restart", W'(exp_seq[i]), SW'(i), i == N, 1'b0);
    end
    step();
    check_idle("restart_after");

    // Backpressure on idx 2, din change and busy start mid-stream.
    start = 1'b1; mode = MODE_SEQ; din = din0;
    step();
    start = 1'b0;
    check_beat("bp0", 7'd10, 3'd0, 1'b0, 1'b0);
    step();
    check_beat("bp1", 7'd20, 3'd1, 1'b0, 1'b0);
    start = 1'b1; mode = MODE_SINGLE; sel = 3'd3; din = {7'd99, 7'd98, 7'd97, 7'd96};
    step();
    start = 1'b0;
    check_beat("bp2", 7'd30, 3'd2, 1'b0, 1'b0);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_beat("bp_hold", 7'd30, 3'd2, 1'b0, 1'b0);
    end
    out_ready = 1'b1;
    step();
    check_beat("bp3", 7'd40, 3'd3, 1'b0, 1'b0);
    step();
    check_beat("bp4", 7'd1, 3'd4, 1'b1, 1'b0);
    step();
    check_idle("bp_after");

    // SINGLE-mode table over every sel value.
    for (int i = 0; i < 8; i++) begin
      start = 1'b1; mode = MODE_SINGLE; sel = tbl[i].sel; din = din0;
      step();
      start = 1'b0;
      check_beat("single", tbl[i].exp_data, tbl[i].sel, 1'b1, tbl[i].exp_err);
      step();
      check_idle("single_after");
    end

    // Reset during beat idx 2 aborts; new request restarts at idx 0.
    start = 1'b1; mode = MODE_SEQ; din = din0;
    step();
    start = 1'b0;
    step();
    step();
    check_beat("pre_rst", 7'd30, 3'd2, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_busy",  32'(busy),      32'd0);
    chk("mrst_data",  32'(out_data),  32'd0);
    chk("mrst_idx",   32'(out_idx),   32'd0);
    chk("mrst_last",  32'(out_last),  32'd0);
    chk("mrst_err",   32'(out_err),   32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i <= N; i++) begin
      check_beat("post_rst", W'(exp_seq[i]), SW'(i), i == N, 1'b0);
      step();
    end
    check_idle("post_rst_after");

    // Wide instance: 6 lanes, 12-bit data, bias 5000 truncated to 904.
    for (int i = 0; i < N2; i++) din2[i*W2 +: W2] = W2'((i + 1) * 300 + i);
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int i = 0; i <= N2; i++) begin
      chk("w12_valid", 32'(out_valid2), 32'd1);
      chk("w12_data",  32'(out_data2),  (i < N2) ? 32'((i + 1) * 300 + i) : 32'(5000 % 4096));
      chk("w12_idx",   32'(out_idx2),   32'(i));
      chk("w12_last",  32'(out_last2),  32'(i == N2));
      chk("w12_err",   32'(out_err2),   32'd0);
      step();
    end
    chk("w12_after_valid", 32'(out_valid2), 32'd0);
    chk("w12_after_busy",  32'(busy2),      32'd0);

    // Randomized traffic against the beat-queue model.
    mq.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      chk("rnd_valid", 32'(out_valid), 32'(mq.size() > 0));
      chk("rnd_busy",  32'(busy),      32'(mq.size() > 0));
      if (mq.size() > 0) begin
        chk("rnd_data", 32'(out_data), 32'(mq[0].data));
        chk("rnd_idx",  32'(out_idx),  32'(mq[0].idx));
        chk("rnd_last", 32'(out_last), 32'(mq[0].last));
        chk("rnd_err",  32'(out_err),  32'(mq[0].err));
      end
      start     = ($urandom_range(0, 2) == 0);
      mode      = 1'($urandom_range(0, 1));
      sel       = SW'($urandom_range(0, 7));
      din       = (N*W)'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if (mq.size() > 0) begin
        if (out_ready) void'(mq.pop_front());
      end else if (start) begin
        push_req(mode, sel, din);
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
